arp_request_resolver: RTL and testbench

//  Responder side of the IP-block ARP request/response interface.
//  - Takes a next-hop IP request and returns the destination MAC, or an error.
//  - Applies subnet/gateway/broadcast rules, then looks the IP up in a small

---
 rtl/arp_request_resolver_pkg.sv | 26 ++
 rtl/arp_request_resolver_cache_table.sv | 89 ++++++++
 rtl/arp_request_resolver.sv | 163 ++++++++++++++++
 tb/tb_arp_request_resolver.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_request_resolver_pkg.sv
// Shared types and constants for the ARP request resolver and its cache table.
package arp_request_resolver_pkg;

  localparam logic [47:0] ArpBroadcastMac = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] IpAllOnes       = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StQuery,
    StWait,
    StRespond
  } arp_state_e;

  typedef enum logic [1:0] {
    ClsNormal,
    ClsBroadcast,
    ClsNoRoute
  } req_class_e;

  // Learned entries carrying the null or all-ones address are never cached.
  function automatic logic entry_ip_ok(logic [31:0] ip);
    return (ip != 32'h0) && (ip != IpAllOnes);
  endfunction

endpackage

// File: rtl/arp_request_resolver_cache_table.sv
// Fully-associative IP->MAC cache with round-robin replacement, in-place overwrite
// and a same-cycle bypass of the learned-entry port onto the lookup result.
module arp_request_resolver_cache_table
  import arp_request_resolver_pkg::*;
#(
  parameter int unsigned Entries = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_cache,
  input  logic        wr_valid,
  input  logic [31:0] wr_ip,
  input  logic [47:0] wr_mac,
  input  logic [31:0] lookup_ip,
  output logic        lookup_hit,
  output logic [47:0] lookup_mac
);

  localparam int unsigned PtrW = $clog2(Entries);

  logic [Entries-1:0] vld_q, vld_d;
  logic [31:0]        ip_q  [Entries];
  logic [31:0]        ip_d  [Entries];
  logic [47:0]        mac_q [Entries];
  logic [47:0]        mac_d [Entries];
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic               wr_hit;
  logic [PtrW-1:0]    wr_idx;
  logic               wr_ok;

  assign wr_ok = wr_valid && entry_ip_ok(wr_ip);

  always_comb begin
    wr_hit     = 1'b0;
    wr_idx     = '0;
    lookup_hit = 1'b0;
    lookup_mac = '0;
    for (int i = 0; i < Entries; i++) begin
      if (vld_q[i] && ip_q[i] == wr_ip) begin
        wr_hit = 1'b1;
        wr_idx = PtrW'(i);
      end
      if (vld_q[i] && ip_q[i] == lookup_ip) begin
        lookup_hit = 1'b1;
        lookup_mac = mac_q[i];
      end
    end
    // A learned entry arriving this cycle is newer than anything stored.
    if (wr_ok && wr_ip == lookup_ip) begin
      lookup_hit = 1'b1;
      lookup_mac = wr_mac;
    end
  end

  always_comb begin
    vld_d = vld_q;
    ip_d  = ip_q;
    mac_d = mac_q;
    ptr_d = ptr_q;
    if (clear_cache) begin
      vld_d = '0;
    end else if (wr_ok) begin
      if (wr_hit) begin
        mac_d[wr_idx] = wr_mac;
      end else begin
        ip_d[ptr_q]  = wr_ip;
        mac_d[ptr_q] = wr_mac;
        vld_d[ptr_q] = 1'b1;
        ptr_d        = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    ip_q  <= ip_d;
    mac_q <= mac_d;
  end

endmodule

// File: rtl/arp_request_resolver.sv
// Resolves next-hop IPs to MACs: subnet/gateway/broadcast classification, cache
// lookup, and query/retry against the ARP frame generator on a miss.
module arp_request_resolver
  import arp_request_resolver_pkg::*;
#(
  parameter int unsigned CACHE_ENTRIES          = 8,
  parameter int unsigned REQUEST_RETRY_COUNT    = 4,
  parameter int unsigned REQUEST_RETRY_INTERVAL = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_request_valid,
  output logic        arp_request_ready,
  input  logic [31:0] arp_request_ip,
  output logic        arp_response_valid,
  input  logic        arp_response_ready,
  output logic        arp_response_error,
  output logic [47:0] arp_response_mac,
  input  logic        s_entry_valid,
  input  logic [31:0] s_entry_ip,
  input  logic [47:0] s_entry_mac,
  output logic        m_query_valid,
  input  logic        m_query_ready,
  output logic [31:0] m_query_ip,
  input  logic [31:0] local_ip,
  input  logic [31:0] gateway_ip,
  input  logic [31:0] subnet_mask,
  input  logic        clear_cache
);

  localparam int unsigned RetryW = $clog2(REQUEST_RETRY_COUNT + 1);
  localparam int unsigned TimerW =
      (REQUEST_RETRY_INTERVAL > 1) ? $clog2(REQUEST_RETRY_INTERVAL) : 1;

  arp_state_e        state_q, state_d;
  req_class_e        cls_q, cls_d;
  logic [31:0]       target_q, target_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [47:0]       resp_mac_q, resp_mac_d;
  logic              resp_err_q, resp_err_d;
  logic              lk_hit;
  logic [47:0]       lk_mac;

  arp_request_resolver_cache_table #(
    .Entries(CACHE_ENTRIES)
  ) u_cache (
    .clk        (clk),
    .rst        (rst),
    .clear_cache(clear_cache),
    .wr_valid   (s_entry_valid),
    .wr_ip      (s_entry_ip),
    .wr_mac     (s_entry_mac),
    .lookup_ip  (target_q),
    .lookup_hit (lk_hit),
    .lookup_mac (lk_mac)
  );

  always_comb begin
    state_d           = state_q;
    cls_d             = cls_q;
    target_d          = target_q;
    retry_d           = retry_q;
    timer_d           = timer_q;
    resp_mac_d        = resp_mac_q;
    resp_err_d        = resp_err_q;
    arp_request_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        arp_request_ready = !rst;
        if (arp_request_valid) begin
          state_d  = StLookup;
          target_d = arp_request_ip;
          cls_d    = ClsNormal;
          if (arp_request_ip == IpAllOnes || (arp_request_ip | subnet_mask) == IpAllOnes) begin
            cls_d = ClsBroadcast;
          end else if ((arp_request_ip & subnet_mask) != (local_ip & subnet_mask)) begin
            target_d = gateway_ip;
            cls_d    = (gateway_ip == 32'h0) ? ClsNoRoute : ClsNormal;
          end
        end
      end
      StLookup: begin
        state_d = StRespond;
        unique case (cls_q)
          ClsBroadcast: begin
            resp_mac_d = ArpBroadcastMac;
            resp_err_d = 1'b0;
          end
          ClsNoRoute: begin
            resp_mac_d = '0;
            resp_err_d = 1'b1;
          end
          default: begin
            if (lk_hit) begin
              resp_mac_d = lk_mac;
              resp_err_d = 1'b0;
            end else begin
              state_d = StQuery;
              retry_d = RetryW'(REQUEST_RETRY_COUNT);
            end
          end
        endcase
      end
      StQuery: begin
        if (m_query_ready) begin
          retry_d = retry_q - 1'b1;
          timer_d = TimerW'(REQUEST_RETRY_INTERVAL - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        // A matching reply beats timer expiry in the same cycle.
        if (s_entry_valid && s_entry_ip == target_q) begin
          resp_mac_d = s_entry_mac;
          resp_err_d = 1'b0;
          state_d    = StRespond;
        end else if (timer_q == '0) begin
          if (retry_q != '0) begin
            state_d = StQuery;
          end else begin
            resp_mac_d = '0;
            resp_err_d = 1'b1;
            state_d    = StRespond;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StRespond: begin
        if (arp_response_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cls_q      <= ClsNormal;
      target_q   <= '0;
      retry_q    <= '0;
      timer_q    <= '0;
      resp_mac_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      target_q   <= target_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      resp_mac_q <= resp_mac_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign arp_response_valid = (state_q == StRespond);
  assign arp_response_mac   = resp_mac_q;
  assign arp_response_error = resp_err_q;
  assign m_query_valid      = (state_q == StQuery);
  assign m_query_ip         = target_q;

endmodule

// File: tb/tb_arp_request_resolver.sv
// Randomised bench for arp_request_resolver against a transaction-level model of
// the classification rules, the cache and the query/retry timeline.
module tb_arp_request_resolver;

  localparam int unsigned Entries  = 8;
  localparam int unsigned Retries  = 3;
  localparam int unsigned Interval = 100;
  localparam logic [31:0] LocalIp  = 32'h0A00_0001;
  localparam logic [31:0] Mask     = 32'hFFFF_FF00;
  localparam logic [31:0] GwIp     = 32'h0A00_00FE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arp_request_valid = 1'b0;
  logic        arp_request_ready;
  logic [31:0] arp_request_ip = '0;
  logic        arp_response_valid;
  logic        arp_response_ready = 1'b0;
  logic        arp_response_error;
  logic [47:0] arp_response_mac;
  logic        s_entry_valid = 1'b0;
  logic [31:0] s_entry_ip = '0;
  logic [47:0] s_entry_mac = '0;
  logic        m_query_valid;
  logic        m_query_ready = 1'b0;
  logic [31:0] m_query_ip;
  logic [31:0] local_ip = LocalIp;
  logic [31:0] gateway_ip = GwIp;
  logic [31:0] subnet_mask = Mask;
  logic        clear_cache = 1'b0;

  always #5 clk = ~clk;

  arp_request_resolver #(
    .CACHE_ENTRIES         (Entries),
    .REQUEST_RETRY_COUNT   (Retries),
    .REQUEST_RETRY_INTERVAL(Interval)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .arp_request_valid (arp_request_valid),
    .arp_request_ready (arp_request_ready),
    .arp_request_ip    (arp_request_ip),
    .arp_response_valid(arp_response_valid),
    .arp_response_ready(arp_response_ready),
    .arp_response_error(arp_response_error),
    .arp_response_mac  (arp_response_mac),
    .s_entry_valid     (s_entry_valid),
    .s_entry_ip        (s_entry_ip),
    .s_entry_mac       (s_entry_mac),
    .m_query_valid     (m_query_valid),
    .m_query_ready     (m_query_ready),
    .m_query_ip        (m_query_ip),
    .local_ip          (local_ip),
    .gateway_ip        (gateway_ip),
    .subnet_mask       (subnet_mask),
    .clear_cache       (clear_cache)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Cache model: a plain table with a replacement index.
  logic [31:0] m_ip  [Entries];
  logic [47:0] m_mac [Entries];
  bit          m_vld [Entries];
  int          m_ptr = 0;

  // What the monitor may see this cycle.
  bit          exp_idle = 1'b0;
  bit          exp_resp_ok = 1'b0;
  bit          exp_query_ok = 1'b0;
  logic [31:0] exp_target = '0;
  logic [47:0] exp_mac = '0;
  logic        exp_err = 1'b0;
  logic [31:0] cfg_gw = GwIp;
  bit          bg_en = 1'b0;
  logic [47:0] last_mac;
  logic        last_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < Entries; i++) m_vld[i] = 1'b0;
    m_ptr = 0;
  endfunction

  function automatic void model_write(input logic v, input logic [31:0] ip,
                                      input logic [47:0] mac, input logic clr);
    if (clr) begin
      for (int i = 0; i < Entries; i++) m_vld[i] = 1'b0;
      return;
    end
    if (!v || ip == 32'h0 || ip == 32'hFFFF_FFFF) return;
    for (int i = 0; i < Entries; i++) begin
      if (m_vld[i] && m_ip[i] == ip) begin
        m_mac[i] = mac;
        return;
      end
    end
    m_ip[m_ptr]  = ip;
    m_mac[m_ptr] = mac;
    m_vld[m_ptr] = 1'b1;
    m_ptr        = (m_ptr + 1) % Entries;
  endfunction

  function automatic bit model_find(input logic [31:0] ip, output logic [47:0] mac);
    mac = '0;
    for (int i = 0; i < Entries; i++) begin
      if (m_vld[i] && m_ip[i] == ip) begin
        mac = m_mac[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // kind: 0 = resolve target, 1 = broadcast, 2 = off-subnet with no gateway
  function automatic void classify(input logic [31:0] ip, input logic [31:0] gw,
                                   output int kind, output logic [31:0] tgt);
    tgt  = ip;
    kind = 0;
    if (ip == 32'hFFFF_FFFF || (ip | Mask) == 32'hFFFF_FFFF) kind = 1;
    else if ((ip & Mask) != (LocalIp & Mask)) begin
      tgt  = gw;
      kind = (gw == 32'h0) ? 2 : 0;
    end
  endfunction

  task automatic tick();
    if (bg_en && !s_entry_valid && $urandom_range(0, 5) == 0) begin
      s_entry_valid = 1'b1;
      s_entry_ip    = ($urandom_range(0, 15) == 0) ? 32'h0 :
                      {24'h0A_0000, 8'($urandom_range(40, 55))};
      s_entry_mac   = {16'($urandom()), $urandom()};
    end
    if (bg_en && $urandom_range(0, 79) == 0) clear_cache = 1'b1;
    @(posedge clk);
    if (rst) model_reset();
    else model_write(s_entry_valid, s_entry_ip, s_entry_mac, clear_cache);
    #1;
    s_entry_valid = 1'b0;
    clear_cache   = 1'b0;
  endtask

  task automatic write_entry(input logic [31:0] ip, input logic [47:0] mac);
    s_entry_valid = 1'b1;
    s_entry_ip    = ip;
    s_entry_mac   = mac;
    tick();
  endtask

  task automatic restore_cfg();
    local_ip    = LocalIp;
    subnet_mask = Mask;
    gateway_ip  = cfg_gw;
  endtask

  // reply_q: query number answered (0 = never), reply_k: cycles after that query.
  task automatic do_request(input logic [31:0] ip, input int reply_q, input int reply_k,
                            input logic [47:0] reply_mac, input int resp_hold,
                            input int rst_after, output int queries);
    int          kind;
    logic [31:0] tgt;
    logic [47:0] found;
    bit          hit;
    int          gap;
    queries = 0;
    classify(ip, gateway_ip, kind, tgt);
    arp_request_valid = 1'b1;
    arp_request_ip    = ip;
    #1;
    check("accept_ready", {63'b0, arp_request_ready}, 64'd1);
    tick();
    arp_request_valid = 1'b0;
    arp_request_ip    = $urandom();
    exp_idle          = 1'b0;
    // Config changes after acceptance must not matter.
    gateway_ip  = $urandom();
    subnet_mask = $urandom();
    local_ip    = $urandom();
    exp_target  = tgt;
    if (kind == 0 && bg_en && $urandom_range(0, 7) == 0) begin
      s_entry_valid = 1'b1;
      s_entry_ip    = tgt;
      s_entry_mac   = {16'($urandom()), $urandom()};
    end
    hit = 1'b0;
    if (kind == 0) begin
      if (s_entry_valid && s_entry_ip == tgt) begin
        hit   = 1'b1;
        found = s_entry_mac;
      end else begin
        hit = model_find(tgt, found);
      end
    end
    if (kind == 1) begin
      exp_mac = 48'hFFFF_FFFF_FFFF;
      exp_err = 1'b0;
    end else if (kind == 2) begin
      exp_mac = '0;
      exp_err = 1'b1;
    end else if (hit) begin
      exp_mac = found;
      exp_err = 1'b0;
    end
    if (kind != 0 || hit) exp_resp_ok = 1'b1;
    else exp_query_ok = 1'b1;
    tick();
    if (!exp_resp_ok) begin
      for (int q = 1; q <= Retries; q++) begin
        check("query_valid", {63'b0, m_query_valid}, 64'd1);
        repeat ($urandom_range(0, 3)) tick();
        m_query_ready = 1'b1;
        tick();
        m_query_ready = 1'b0;
        queries++;
        if (rst_after > 0) begin
          repeat (rst_after) tick();
          rst = 1'b1;
          tick();
          check("rst_query_valid", {63'b0, m_query_valid}, 64'd0);
          check("rst_query_ip", {32'b0, m_query_ip}, 64'd0);
          check("rst_resp_valid", {63'b0, arp_response_valid}, 64'd0);
          check("rst_resp_mac", {16'b0, arp_response_mac}, 64'd0);
          check("rst_req_ready", {63'b0, arp_request_ready}, 64'd0);
          exp_query_ok = 1'b0;
          exp_resp_ok  = 1'b0;
          exp_idle     = 1'b1;
          rst          = 1'b0;
          #1;
          check("rst_release_ready", {63'b0, arp_request_ready}, 64'd1);
          restore_cfg();
          return;
        end
        if (q == reply_q) begin
          repeat (reply_k - 1) tick();
          s_entry_valid = 1'b1;
          s_entry_ip    = tgt;
          s_entry_mac   = reply_mac;
          exp_mac       = reply_mac;
          exp_err       = 1'b0;
          exp_resp_ok   = 1'b1;
          tick();
          exp_query_ok = 1'b0;
          break;
        end
        if (q == Retries) begin
          exp_mac     = '0;
          exp_err     = 1'b1;
          exp_resp_ok = 1'b1;
        end
        gap = 0;
        while (!m_query_valid && !arp_response_valid && gap < Interval + 5) begin
          tick();
          gap++;
        end
        check("retry_gap", 64'(gap), 64'(Interval));
        if (q == Retries) exp_query_ok = 1'b0;
      end
    end
    check("resp_valid", {63'b0, arp_response_valid}, 64'd1);
    check("resp_mac", {16'b0, arp_response_mac}, {16'b0, exp_mac});
    check("resp_err", {63'b0, arp_response_error}, {63'b0, exp_err});
    last_mac = arp_response_mac;
    last_err = arp_response_error;
    repeat (resp_hold) begin
      tick();
      check("resp_held", {63'b0, arp_response_valid}, 64'd1);
    end
    arp_response_ready = 1'b1;
    tick();
    arp_response_ready = 1'b0;
    exp_resp_ok        = 1'b0;
    exp_query_ok       = 1'b0;
    exp_idle           = 1'b1;
    check("resp_done", {63'b0, arp_response_valid}, 64'd0);
    restore_cfg();
  endtask

  // Per-cycle comparison of the DUT outputs against the current expectations.
  always @(negedge clk) begin
    if (!rst) begin
      check("req_ready", {63'b0, arp_request_ready}, {63'b0, exp_idle});
      if (!exp_query_ok) check("no_query", {63'b0, m_query_valid}, 64'd0);
      if (m_query_valid) check("query_ip", {32'b0, m_query_ip}, {32'b0, exp_target});
      if (!exp_resp_ok) check("no_response", {63'b0, arp_response_valid}, 64'd0);
      if (arp_response_valid) begin
        check("mon_mac", {16'b0, arp_response_mac}, {16'b0, exp_mac});
        check("mon_err", {63'b0, arp_response_error}, {63'b0, exp_err});
      end
    end
  end

  function automatic logic [31:0] pick_ip();
    case ($urandom_range(0, 5))
      0, 1:    return {24'h0A_0000, 8'($urandom_range(2, 12))};
      2:       return 32'h0A00_00FF;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0808_0808;
      default: return {24'h0A_0001, 8'($urandom_range(1, 200))};
    endcase
  endfunction

  initial begin
    int nq;
    model_reset();
    repeat (3) tick();
    check("rst_ready_low", {63'b0, arp_request_ready}, 64'd0);
    rst      = 1'b0;
    exp_idle = 1'b1;
    #1;
    check("reset_resp_valid", {63'b0, arp_response_valid}, 64'd0);
    check("reset_query_valid", {63'b0, m_query_valid}, 64'd0);
    check("reset_mac", {16'b0, arp_response_mac}, 64'd0);
    check("reset_err", {63'b0, arp_response_error}, 64'd0);
    check("reset_ready", {63'b0, arp_request_ready}, 64'd1);
    tick();

    // Cached on-subnet hit.
    write_entry(32'h0A00_0002, 48'h0200_0000_0002);
    do_request(32'h0A00_0002, 0, 0, '0, 0, 0, nq);
    check("t1_mac", {16'b0, last_mac}, 64'h0200_0000_0002);
    check("t1_err", {63'b0, last_err}, 64'd0);

    // Broadcast forms, no query.
    do_request(32'h0A00_00FF, 0, 0, '0, 0, 0, nq);
    check("t2_subnet_bcast_mac", {16'b0, last_mac}, 64'hFFFF_FFFF_FFFF);
    check("t2_subnet_bcast_nq", 64'(nq), 64'd0);
    do_request(32'hFFFF_FFFF, 0, 0, '0, 0, 0, nq);
    check("t2_all_ones_mac", {16'b0, last_mac}, 64'hFFFF_FFFF_FFFF);

    // Off-subnet via gateway, then with no gateway.
    write_entry(GwIp, 48'h0A0B_0C0D_0E0F);
    do_request(32'h0808_0808, 0, 0, '0, 0, 0, nq);
    check("t3_gw_mac", {16'b0, last_mac}, 64'h0A0B_0C0D_0E0F);
    cfg_gw     = 32'h0;
    gateway_ip = cfg_gw;
    do_request(32'h0808_0808, 0, 0, '0, 0, 0, nq);
    check("t3_nogw_err", {63'b0, last_err}, 64'd1);
    check("t3_nogw_nq", 64'(nq), 64'd0);
    cfg_gw     = GwIp;
    gateway_ip = cfg_gw;

    // Miss answered 50 cycles after the second query.
    do_request(32'h0A00_0009, 2, 50, 48'h0200_0000_0009, 0, 0, nq);
    check("t4_nq", 64'(nq), 64'd2);
    check("t4_mac", {16'b0, last_mac}, 64'h0200_0000_0009);

    // Miss never answered, response held off for 5 cycles.
    do_request(32'h0A00_000A, 0, 0, '0, 5, 0, nq);
    check("t5_nq", 64'(nq), 64'd3);
    check("t5_err", {63'b0, last_err}, 64'd1);
    check("t5_mac", {16'b0, last_mac}, 64'd0);

    // Reply landing on the exact expiry cycle of the last wait.
    do_request(32'h0A00_000B, 3, Interval, 48'h0200_0000_000B, 0, 0, nq);
    check("t5_edge_mac", {16'b0, last_mac}, 64'h0200_0000_000B);

    // Round-robin eviction of the oldest of nine fresh entries.
    clear_cache = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) write_entry(32'h0A00_0014 + 32'(i), 48'h0300_0000_0000 + 48'(i));
    do_request(32'h0A00_001C, 0, 0, '0, 0, 0, nq);
    check("t6_newest_hit_nq", 64'(nq), 64'd0);
    do_request(32'h0A00_0014, 1, 5, 48'h0400_0000_0014, 0, 0, nq);
    check("t6_evicted_nq", 64'(nq), 64'd1);

    // Clear wins over a same-cycle write.
    clear_cache   = 1'b1;
    s_entry_valid = 1'b1;
    s_entry_ip    = 32'h0A00_0030;
    s_entry_mac   = 48'h0500_0000_0030;
    tick();
    do_request(32'h0A00_0030, 1, 3, 48'h0600_0000_0030, 0, 0, nq);
    check("t6_clear_write_nq", 64'(nq), 64'd1);
    do_request(32'h0A00_001C, 1, 3, 48'h0600_0000_001C, 0, 0, nq);
    check("t6_clear_old_nq", 64'(nq), 64'd1);

    // Reset during WAIT, then the cache must be empty.
    do_request(32'h0A00_000C, 0, 0, '0, 0, 10, nq);
    tick();
    do_request(32'h0A00_001C, 1, 2, 48'h0700_0000_001C, 0, 0, nq);
    check("t6_post_rst_nq", 64'(nq), 64'd1);

    // Randomised traffic with background learning and clears.
    bg_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      cfg_gw     = ($urandom_range(0, 4) == 0) ? 32'h0 : GwIp;
      gateway_ip = cfg_gw;
      if ($urandom_range(0, 3) == 0) write_entry(GwIp, {16'($urandom()), $urandom()});
      repeat ($urandom_range(0, 3)) tick();
      do_request(pick_ip(), int'($urandom_range(0, Retries)), int'($urandom_range(1, Interval)),
                 {16'($urandom()), $urandom()}, int'($urandom_range(0, 3)), 0, nq);
    end
    bg_en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
